// File: rtl/tile_loop_sequencer.sv
// Control FSM for the tiled matrix multiply: walks C tiles (i,j) and their k blocks,
// strobing the A/B/C block memories and the systolic core for each step.
module tile_loop_sequencer #(
    parameter int NUM_BLOCKS   = 4,
    parameter int BLOCK_SIZE   = 64,
    parameter int ADDR_WIDTH   = 10,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  systolic_done,
    output logic                  done,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_a_addr_out,
    output logic                  mem_a_rd_out,
    output logic [ADDR_WIDTH-1:0] mem_b_addr_out,
    output logic                  mem_b_rd_out,
    output logic [ADDR_WIDTH-1:0] mem_c_addr_out,
    output logic                  mem_c_rd_out,
    output logic                  mem_c_wr_out,
    output logic                  init_c_block_out,
    output logic                  systolic_start_out,
    output logic                  systolic_rst_out
);

    localparam int IW  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [IW-1:0]  IDX_LAST   = IW'(NUM_BLOCKS - 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT_C, S_LOAD, S_CLR, S_RUN, S_DRAIN, S_WRITE, S_NEXT, S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [IW-1:0]  i_idx, j_idx, k_idx;
    logic [IW-1:0]  i_nxt, j_nxt, k_nxt;
    logic [DCW-1:0] drain_cnt, drain_nxt;

    // Block-major layout: tile (r,c) starts at (r*NUM_BLOCKS + c)*BLOCK_SIZE.
    function automatic logic [ADDR_WIDTH-1:0] tile_base(input logic [IW-1:0] r,
                                                        input logic [IW-1:0] c);
        logic [31:0] idx;
        idx = (32'(r) * 32'(NUM_BLOCKS) + 32'(c)) * 32'(BLOCK_SIZE);
        return idx[ADDR_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            i_idx          <= '0;
            j_idx          <= '0;
            k_idx          <= '0;
            drain_cnt      <= '0;
            mem_a_addr_out <= '0;
            mem_b_addr_out <= '0;
            mem_c_addr_out <= '0;
        end else begin
            state          <= state_nxt;
            i_idx          <= i_nxt;
            j_idx          <= j_nxt;
            k_idx          <= k_nxt;
            drain_cnt      <= drain_nxt;
            // Addresses follow the next indices so they are stable before the strobes.
            mem_a_addr_out <= tile_base(i_nxt, k_nxt);
            mem_b_addr_out <= tile_base(k_nxt, j_nxt);
            mem_c_addr_out <= tile_base(i_nxt, j_nxt);
        end
    end

    always_comb begin
        state_nxt          = state;
        i_nxt              = i_idx;
        j_nxt              = j_idx;
        k_nxt              = k_idx;
        drain_nxt          = drain_cnt;
        done               = 1'b0;
        busy               = (state != S_IDLE) && (state != S_DONE);
        mem_a_rd_out       = 1'b0;
        mem_b_rd_out       = 1'b0;
        mem_c_rd_out       = 1'b0;
        mem_c_wr_out       = 1'b0;
        init_c_block_out   = 1'b0;
        systolic_start_out = 1'b0;
        systolic_rst_out   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_INIT_C;
                    i_nxt     = '0;
                    j_nxt     = '0;
                    k_nxt     = '0;
                end
            end
            S_INIT_C: begin
                init_c_block_out = 1'b1;
                state_nxt        = S_LOAD;
            end
            S_LOAD: begin
                mem_a_rd_out = 1'b1;
                mem_b_rd_out = 1'b1;
                mem_c_rd_out = 1'b1;
                state_nxt    = S_CLR;
            end
            S_CLR: begin
                systolic_rst_out = 1'b1;
                state_nxt        = S_RUN;
            end
            S_RUN: begin
                systolic_start_out = 1'b1;
                if (systolic_done) begin
                    drain_nxt = '0;
                    state_nxt = (DRAIN_CYCLES == 0) ? S_WRITE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) state_nxt = S_WRITE;
                else                         drain_nxt = drain_cnt + DCW'(1);
            end
            S_WRITE: begin
                mem_c_wr_out = 1'b1;
                state_nxt    = S_NEXT;
            end
            S_NEXT: begin
                // k inner, j middle, i outer; a fresh C tile restarts at INIT_C.
                if (k_idx != IDX_LAST) begin
                    k_nxt     = k_idx + IW'(1);
                    state_nxt = S_LOAD;
                end else begin
                    k_nxt = '0;
                    if (j_idx != IDX_LAST) begin
                        j_nxt     = j_idx + IW'(1);
                        state_nxt = S_INIT_C;
                    end else begin
                        j_nxt = '0;
                        if (i_idx != IDX_LAST) begin
                            i_nxt     = i_idx + IW'(1);
                            state_nxt = S_INIT_C;
                        end else begin
                            i_nxt     = '0;
                            state_nxt = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tile_loop_sequencer.sv
// Directed bench for tile_loop_sequencer: three instances cover N=1/DRAIN=2,
// N=4/DRAIN=2 and N=1/DRAIN=0 configurations.
module tb_tile_loop_sequencer;

    localparam int AW = 10;
    // Observed vector: {busy, done, init, rd_a, rd_b, rd_c, wr, sys_rst, sys_start}
    localparam logic [8:0] V_IDLE = 9'b000000000;
    localparam logic [8:0] V_INIT = 9'b101000000;
    localparam logic [8:0] V_LOAD = 9'b100111000;
    localparam logic [8:0] V_CLR  = 9'b100000010;
    localparam logic [8:0] V_RUN  = 9'b100000001;
    localparam logic [8:0] V_WAIT = 9'b100000000;
    localparam logic [8:0] V_WR   = 9'b100000100;
    localparam logic [8:0] V_DONE = 9'b010000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // ---------------- instance A: N=1, DRAIN=2 ----------------
    logic rst_a, start_a, sd_a, done_a, busy_a, ra_a, rb_a, rc_a, wr_a, init_a, ss_a, srst_a;
    logic [AW-1:0] aa_a, ab_a, ac_a;
    int run_a = 0;
    tile_loop_sequencer #(.NUM_BLOCKS(1), .BLOCK_SIZE(64), .ADDR_WIDTH(AW), .DRAIN_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .systolic_done(sd_a), .done(done_a), .busy(busy_a),
        .mem_a_addr_out(aa_a), .mem_a_rd_out(ra_a), .mem_b_addr_out(ab_a), .mem_b_rd_out(rb_a),
        .mem_c_addr_out(ac_a), .mem_c_rd_out(rc_a), .mem_c_wr_out(wr_a), .init_c_block_out(init_a),
        .systolic_start_out(ss_a), .systolic_rst_out(srst_a));
    wire [8:0] va = {busy_a, done_a, init_a, ra_a, rb_a, rc_a, wr_a, srst_a, ss_a};
    // Core model: done rises in the third consecutive RUN cycle.
    always @(posedge clk) run_a <= ss_a ? run_a + 1 : 0;
    assign sd_a = (run_a >= 2);

    // ---------------- instance B: N=4, DRAIN=2 ----------------
    logic rst_b, start_b, sd_b, done_b, busy_b, ra_b, rb_b, rc_b, wr_b, init_b, ss_b, srst_b;
    logic [AW-1:0] aa_b, ab_b, ac_b;
    int run_b = 0;
    tile_loop_sequencer #(.NUM_BLOCKS(4), .BLOCK_SIZE(64), .ADDR_WIDTH(AW), .DRAIN_CYCLES(2)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .systolic_done(sd_b), .done(done_b), .busy(busy_b),
        .mem_a_addr_out(aa_b), .mem_a_rd_out(ra_b), .mem_b_addr_out(ab_b), .mem_b_rd_out(rb_b),
        .mem_c_addr_out(ac_b), .mem_c_rd_out(rc_b), .mem_c_wr_out(wr_b), .init_c_block_out(init_b),
        .systolic_start_out(ss_b), .systolic_rst_out(srst_b));
    wire [8:0] vb = {busy_b, done_b, init_b, ra_b, rb_b, rc_b, wr_b, srst_b, ss_b};
    always @(posedge clk) run_b <= ss_b ? run_b + 1 : 0;
    assign sd_b = (run_b >= 2);

    // Strobe counters and address capture for instance B, sampled mid-cycle.
    logic clr_b = 1'b0;
    int wr_n = 0, init_n = 0, clr_n = 0, done_n = 0, ld_n = 0, excl_n = 0;
    logic [AW-1:0] cap_la, cap_lb, cap_lc, cap_wa, cap_wb, cap_wc;
    always @(negedge clk) begin
        if (clr_b) begin
            wr_n <= 0; init_n <= 0; clr_n <= 0; done_n <= 0; ld_n <= 0; excl_n <= 0;
        end else begin
            if (wr_b) begin
                if (wr_n == 27) begin cap_wa <= aa_b; cap_wb <= ab_b; cap_wc <= ac_b; end
                wr_n <= wr_n + 1;
            end
            if (ra_b) begin
                if (ld_n == 27) begin cap_la <= aa_b; cap_lb <= ab_b; cap_lc <= ac_b; end
                ld_n <= ld_n + 1;
            end
            if (init_b) init_n <= init_n + 1;
            if (srst_b) clr_n <= clr_n + 1;
            if (done_b) done_n <= done_n + 1;
            if ($countones({init_b, ra_b, wr_b, srst_b, ss_b}) > 1) excl_n <= excl_n + 1;
        end
    end

    // ---------------- instance C: N=1, DRAIN=0 ----------------
    logic rst_c, start_c, sd_c, done_c, busy_c, ra_c, rb_c, rc_c, wr_c, init_c, ss_c, srst_c;
    logic [AW-1:0] aa_c, ab_c, ac_c;
    tile_loop_sequencer #(.NUM_BLOCKS(1), .BLOCK_SIZE(64), .ADDR_WIDTH(AW), .DRAIN_CYCLES(0)) dut_c (
        .clk(clk), .rst(rst_c), .start(start_c), .systolic_done(sd_c), .done(done_c), .busy(busy_c),
        .mem_a_addr_out(aa_c), .mem_a_rd_out(ra_c), .mem_b_addr_out(ab_c), .mem_b_rd_out(rb_c),
        .mem_c_addr_out(ac_c), .mem_c_rd_out(rc_c), .mem_c_wr_out(wr_c), .init_c_block_out(init_c),
        .systolic_start_out(ss_c), .systolic_rst_out(srst_c));
    wire [8:0] vc = {busy_c, done_c, init_c, ra_c, rb_c, rc_c, wr_c, srst_c, ss_c};

    logic [8:0] seq1 [11] = '{V_INIT, V_LOAD, V_CLR, V_RUN, V_RUN, V_RUN, V_WAIT, V_WAIT, V_WR, V_WAIT, V_DONE};
    logic [8:0] seq5 [7]  = '{V_INIT, V_LOAD, V_CLR, V_RUN, V_WR, V_WAIT, V_DONE};

    initial begin
        bit ok;
        int dev;
        rst_a = 1; rst_b = 1; rst_c = 1;
        start_a = 0; start_b = 1; start_c = 0; sd_c = 1;
        // start held during reset must be overridden
        repeat (3) @(negedge clk);
        check("rst_vec_a", 32'(va), 32'(V_IDLE));
        check("rst_vec_b", 32'(vb), 32'(V_IDLE));
        check("rst_vec_c", 32'(vc), 32'(V_IDLE));
        check("rst_addr_b", 32'({aa_b, ab_b, ac_b}), 32'd0);
        start_b = 0;
        rst_a = 0; rst_b = 0; rst_c = 0;

        // 1: single-tile sequence on instance A
        @(negedge clk) start_a = 1;
        @(negedge clk) start_a = 0;
        for (int n = 0; n < 11; n++) begin
            check($sformatf("t1_seq%0d", n), 32'(va), 32'(seq1[n]));
            @(negedge clk);
        end
        check("t1_idle_after", 32'(va), 32'(V_IDLE));

        // 2: full 4x4 sweep on instance B
        clr_b = 1; @(negedge clk); clr_b = 0;
        start_b = 1; @(negedge clk) start_b = 0;
        ok = 0;
        for (int c = 0; c < 1000 && !ok; c++) begin
            @(negedge clk);
            if (done_b) ok = 1;
        end
        check("t2_done_seen", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        check("t2_load_a", 32'(cap_la), 32'd448);
        check("t2_load_b", 32'(cap_lb), 32'd896);
        check("t2_load_c", 32'(cap_lc), 32'd384);
        check("t2_write_a", 32'(cap_wa), 32'd448);
        check("t2_write_b", 32'(cap_wb), 32'd896);
        check("t2_write_c", 32'(cap_wc), 32'd384);
        check("t2_wr_count", 32'(wr_n), 32'd64);
        check("t2_init_count", 32'(init_n), 32'd16);
        check("t2_clr_count", 32'(clr_n), 32'd64);
        check("t2_done_count", 32'(done_n), 32'd1);
        check("t2_exclusive", 32'(excl_n), 32'd0);

        // 3: start held high through the whole run
        clr_b = 1; @(negedge clk); clr_b = 0;
        start_b = 1;
        ok = 0;
        for (int c = 0; c < 1000 && !ok; c++) begin
            @(negedge clk);
            if (done_b) ok = 1;
        end
        check("t3_done_seen", 32'(ok), 32'd1);
        check("t3_busy_at_done", 32'(busy_b), 32'd0);
        start_b = 0;
        repeat (3) @(negedge clk);
        check("t3_idle", 32'(vb), 32'(V_IDLE));
        check("t3_init_count", 32'(init_n), 32'd16);
        check("t3_done_count", 32'(done_n), 32'd1);

        // 4: restart, then reset during RUN of k=2
        clr_b = 1; @(negedge clk); clr_b = 0;
        start_b = 1; @(negedge clk) start_b = 0;
        check("t4_restart", 32'(vb), 32'(V_INIT));
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (ld_n == 3 && ss_b) ok = 1;
        end
        check("t4_reach_run_k2", 32'(ok), 32'd1);
        rst_b = 1;
        @(negedge clk);
        check("t4_rst_vec", 32'(vb), 32'(V_IDLE));
        check("t4_rst_addr", 32'({aa_b, ab_b, ac_b}), 32'd0);
        rst_b = 0;
        repeat (4) @(negedge clk);
        check("t4_no_writeback", 32'(wr_n), 32'd2);
        check("t4_still_idle", 32'(vb), 32'(V_IDLE));
        start_b = 1; @(negedge clk) start_b = 0;
        check("t4_new_init", 32'(vb), 32'(V_INIT));
        check("t4_new_c_addr", 32'(ac_b), 32'd0);
        @(negedge clk);
        check("t4_new_load", 32'(vb), 32'(V_LOAD));
        check("t4_new_ab_addr", 32'({aa_b, ab_b}), 32'd0);
        rst_b = 1; @(negedge clk); rst_b = 0;

        // 5: systolic_done stuck high from IDLE, DRAIN_CYCLES=0
        repeat (2) @(negedge clk);
        check("t5_idle_with_done", 32'(vc), 32'(V_IDLE));
        start_c = 1; @(negedge clk) start_c = 0;
        for (int n = 0; n < 7; n++) begin
            check($sformatf("t5_seq%0d", n), 32'(vc), 32'(seq5[n]));
            @(negedge clk);
        end
        check("t5_idle_after", 32'(vc), 32'(V_IDLE));
        // systolic_done stuck low: RUN must hold indefinitely
        sd_c = 0;
        start_c = 1; @(negedge clk) start_c = 0;
        ok = 0;
        for (int c = 0; c < 10 && !ok; c++) begin
            if (ss_c) ok = 1;
            else @(negedge clk);
        end
        check("t5_reach_run", 32'(ok), 32'd1);
        dev = 0;
        for (int c = 0; c < 20; c++) begin
            if (vc != V_RUN) dev++;
            @(negedge clk);
        end
        check("t5_stuck_in_run", 32'(dev), 32'd0);
        rst_c = 1; @(negedge clk); rst_c = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
